// File: rtl/param_sync_fifo_pkg.sv
// Shared FIFO helpers: occupancy/pointer sizing and explicit wrap-around pointer increment.
// Reused by both the synchronous FIFO and the future asynchronous variant.
package param_sync_fifo_pkg;

  // Operation applied to the FIFO on a clock edge: {pop, push}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifoOp_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address entries 0..depth-1.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Non-power-of-two depths need an explicit wrap rather than masking.
  function automatic int ptrNext(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// FIFO storage: WIDTH x DEPTH register array, synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the pointer/count logic.
module param_sync_fifo_mem
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ptrWidth(DEPTH)-1:0] wAddr,
  input  logic [WIDTH-1:0]           wData,
  input  logic [ptrWidth(DEPTH)-1:0] rAddr,
  output logic [WIDTH-1:0]           rData
);

  logic [WIDTH-1:0] store [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      store[wAddr] <= wData;
    end
  end

  assign rData = store[rAddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, programmable almost flags,
// one-cycle overflow/underflow pulses and optional empty-bypass.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wEn,
  input  logic [WIDTH-1:0]             dIn,
  input  logic                         rEn,
  output logic [WIDTH-1:0]             dOut,
  output logic                         full,
  output logic                         empty,
  output logic                         almostFull,
  output logic                         almostEmpty,
  output logic [countWidth(DEPTH)-1:0] count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = countWidth(DEPTH);

  if (WIDTH < 1 || DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : gBadParams
    $error("param_sync_fifo: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] cnt;
  logic             ovfPulse;
  logic             unfPulse;

  logic             isFull;
  logic             isEmpty;
  logic             bypassNow;
  logic             wrAcc;
  logic             rdAcc;
  logic             memWe;
  logic             popHead;
  logic [WIDTH-1:0] memData;
  fifoOp_e          op;

  // Status decoded only from registered count, so no wEn/rEn path reaches full/empty.
  assign isFull  = (cnt == CNT_W'(DEPTH));
  assign isEmpty = (cnt == '0);

  // Acceptance; a bypassed pair is accepted but never touches storage or pointers.
  assign bypassNow = BYPASS && isEmpty && wEn && rEn;
  assign wrAcc     = wEn && (!isFull || rEn);
  assign rdAcc     = rEn && (!isEmpty || (BYPASS && wEn));
  assign memWe     = wrAcc && !bypassNow;
  assign popHead   = rdAcc && !bypassNow;
  assign op        = fifoOp_e'({popHead, memWe});

  param_sync_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) uMem (
    .clk  (clk),
    .we   (memWe),
    .wAddr(wrPtr),
    .wData(dIn),
    .rAddr(rdPtr),
    .rData(memData)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      cnt      <= '0;
      ovfPulse <= 1'b0;
      unfPulse <= 1'b0;
    end else begin
      if (memWe) begin
        wrPtr <= PTR_W'(ptrNext(int'(wrPtr), DEPTH));
      end
      if (popHead) begin
        rdPtr <= PTR_W'(ptrNext(int'(rdPtr), DEPTH));
      end
      case (op)
        OP_PUSH: cnt <= cnt + 1'b1;
        OP_POP:  cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ovfPulse <= wEn && isFull && !rEn;
      unfPulse <= rEn && isEmpty && !(BYPASS && wEn);
    end
  end

  // Head is shown ahead; an empty FIFO presents zeros unless passing dIn through.
  always_comb begin
    dOut = memData;
    if (bypassNow) begin
      dOut = dIn;
    end else if (isEmpty) begin
      dOut = '0;
    end
  end

  assign full        = isFull;
  assign empty       = isEmpty;
  assign almostFull  = (cnt >= CNT_W'(AF_THRESH));
  assign almostEmpty = (cnt <= CNT_W'(AE_THRESH));
  assign count       = cnt;
  assign overflow    = ovfPulse;
  assign underflow   = unfPulse;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: three configurations driven with the same stimulus,
// directed scenarios plus randomized traffic checked against a shift-array reference model.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wEn = 1'b0;
  logic       rEn = 1'b0;
  logic [5:0] dIn = '0;

  // Index 0: DEPTH=4 defaults; 1: DEPTH=5; 2: DEPTH=4, BYPASS=0, AF=2, AE=0.
  logic [5:0] dOutV   [3];
  logic       fullV   [3];
  logic       emptyV  [3];
  logic       afV     [3];
  logic       aeV     [3];
  logic [2:0] countV  [3];
  logic       ovfV    [3];
  logic       unfV    [3];

  int checks   = 0;
  int failures = 0;

  // Reference model: element 0 is the head; pops shift everything down.
  logic [5:0] mq  [3][8];
  int         msz [3]    = '{0, 0, 0};
  bit         mOvf[3]    = '{0, 0, 0};
  bit         mUnf[3]    = '{0, 0, 0};
  int         depthM[3]  = '{4, 5, 4};
  bit         bypM[3]    = '{1, 1, 0};
  int         afM[3]     = '{3, 4, 2};
  int         aeM[3]     = '{1, 1, 0};

  always #5 clk = ~clk;

  param_sync_fifo uA (
    .clk(clk), .rst(rst), .wEn(wEn), .dIn(dIn), .rEn(rEn), .dOut(dOutV[0]),
    .full(fullV[0]), .empty(emptyV[0]), .almostFull(afV[0]), .almostEmpty(aeV[0]),
    .count(countV[0]), .overflow(ovfV[0]), .underflow(unfV[0])
  );

  param_sync_fifo #(.WIDTH(6), .DEPTH(5)) uB (
    .clk(clk), .rst(rst), .wEn(wEn), .dIn(dIn), .rEn(rEn), .dOut(dOutV[1]),
    .full(fullV[1]), .empty(emptyV[1]), .almostFull(afV[1]), .almostEmpty(aeV[1]),
    .count(countV[1]), .overflow(ovfV[1]), .underflow(unfV[1])
  );

  param_sync_fifo #(.WIDTH(6), .DEPTH(4), .AF_THRESH(2), .AE_THRESH(0), .BYPASS(1'b0)) uC (
    .clk(clk), .rst(rst), .wEn(wEn), .dIn(dIn), .rEn(rEn), .dOut(dOutV[2]),
    .full(fullV[2]), .empty(emptyV[2]), .almostFull(afV[2]), .almostEmpty(aeV[2]),
    .count(countV[2]), .overflow(ovfV[2]), .underflow(unfV[2])
  );

  // Advance the model with the inputs present at the coming edge, then cross it.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      bit isF, isE, byp, wA, rA;
      if (!rst) begin
        msz[i]  = 0;
        mOvf[i] = 1'b0;
        mUnf[i] = 1'b0;
      end else begin
        isF     = (msz[i] == depthM[i]);
        isE     = (msz[i] == 0);
        byp     = isE && wEn && rEn && bypM[i];
        wA      = wEn && (!isF || rEn);
        rA      = rEn && (!isE || (bypM[i] && wEn));
        mOvf[i] = wEn && isF && !rEn;
        mUnf[i] = rEn && isE && !(bypM[i] && wEn);
        if (!byp) begin
          if (rA) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k + 1];
            msz[i]--;
          end
          if (wA) begin
            mq[i][msz[i]] = dIn;
            msz[i]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] expOut(input int i);
    if (msz[i] != 0) return mq[i][0];
    return (bypM[i] && wEn && rEn) ? dIn : 6'd0;
  endfunction

  task automatic fillA(input int n);
    for (int v = 1; v <= n; v++) begin
      wEn = 1'b1;
      dIn = 6'(v);
      step();
    end
    wEn = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wEn = 1'b1; rEn = 1'b0; dIn = 6'd21;
    step();
    wEn = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (countV[i] !== 3'd0) begin failures++; $display("FAIL reset_count dut%0d got=%0d exp=0", i, countV[i]); end
      checks++; if (emptyV[i] !== 1'b1) begin failures++; $display("FAIL reset_empty dut%0d got=%b exp=1", i, emptyV[i]); end
      checks++; if (fullV[i] !== 1'b0) begin failures++; $display("FAIL reset_full dut%0d got=%b exp=0", i, fullV[i]); end
      checks++; if (afV[i] !== 1'b0) begin failures++; $display("FAIL reset_af dut%0d got=%b exp=0", i, afV[i]); end
      checks++; if (aeV[i] !== 1'b1) begin failures++; $display("FAIL reset_ae dut%0d got=%b exp=1", i, aeV[i]); end
      checks++; if (ovfV[i] !== 1'b0 || unfV[i] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b%b exp=00", i, ovfV[i], unfV[i]); end
      checks++; if (dOutV[i] !== 6'd0) begin failures++; $display("FAIL reset_dout dut%0d got=%0d exp=0", i, dOutV[i]); end
    end
    rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int v = 1; v <= 4; v++) begin
      wEn = 1'b1; dIn = 6'(v);
      step();
      checks++; if (countV[0] !== 3'(v)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", countV[0], v); end
      checks++; if (afV[0] !== (v >= 3)) begin failures++; $display("FAIL fill_af n=%0d got=%b exp=%b", v, afV[0], (v >= 3)); end
      checks++; if (fullV[0] !== (v == 4)) begin failures++; $display("FAIL fill_full n=%0d got=%b exp=%b", v, fullV[0], (v == 4)); end
      checks++; if (dOutV[0] !== 6'd1) begin failures++; $display("FAIL fill_head got=%0d exp=1", dOutV[0]); end
    end
    wEn = 1'b0; rEn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (dOutV[0] !== 6'(k)) begin failures++; $display("FAIL drain_data got=%0d exp=%0d", dOutV[0], k); end
      step();
    end
    rEn = 1'b0; #1;
    checks++; if (emptyV[0] !== 1'b1 || countV[0] !== 3'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", emptyV[0], countV[0]); end
    checks++; if (dOutV[0] !== 6'd0) begin failures++; $display("FAIL drain_dout got=%0d exp=0", dOutV[0]); end
  endtask

  task automatic test_full_rw();
    logic [5:0] expSeq [4];
    expSeq = '{6'd2, 6'd3, 6'd4, 6'd9};
    fillA(4);
    wEn = 1'b1; rEn = 1'b1; dIn = 6'd9;
    step();
    wEn = 1'b0; rEn = 1'b0; #1;
    checks++; if (countV[0] !== 3'd4 || fullV[0] !== 1'b1) begin failures++; $display("FAIL fullrw_state got=%0d/%b exp=4/1", countV[0], fullV[0]); end
    checks++; if (ovfV[0] !== 1'b0) begin failures++; $display("FAIL fullrw_ovf got=%b exp=0", ovfV[0]); end
    rEn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (dOutV[0] !== expSeq[k]) begin failures++; $display("FAIL fullrw_data got=%0d exp=%0d", dOutV[0], expSeq[k]); end
      step();
    end
    rEn = 1'b0; #1;
  endtask

  task automatic test_errors();
    fillA(4);
    wEn = 1'b1; dIn = 6'd33;
    step();
    wEn = 1'b0; #1;
    checks++; if (ovfV[0] !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ovfV[0]); end
    checks++; if (countV[0] !== 3'd4 || dOutV[0] !== 6'd1) begin failures++; $display("FAIL ovf_state got=%0d/%0d exp=4/1", countV[0], dOutV[0]); end
    checks++; if (ovfV[1] !== 1'b0) begin failures++; $display("FAIL ovf_depth5 got=%b exp=0", ovfV[1]); end
    step();
    checks++; if (ovfV[0] !== 1'b0) begin failures++; $display("FAIL ovf_width got=%b exp=0", ovfV[0]); end
    rEn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (dOutV[0] !== 6'(k)) begin failures++; $display("FAIL ovf_contents got=%0d exp=%0d", dOutV[0], k); end
      step();
    end
    step();
    rEn = 1'b0; #1;
    checks++; if (unfV[0] !== 1'b1 || countV[0] !== 3'd0) begin failures++; $display("FAIL unf_pulse got=%b/%0d exp=1/0", unfV[0], countV[0]); end
    checks++; if (unfV[1] !== 1'b0) begin failures++; $display("FAIL unf_depth5 got=%b exp=0", unfV[1]); end
    step();
    checks++; if (unfV[0] !== 1'b0) begin failures++; $display("FAIL unf_width got=%b exp=0", unfV[0]); end
  endtask

  task automatic test_bypass();
    wEn = 1'b1; rEn = 1'b1; dIn = 6'd7; #1;
    checks++; if (dOutV[0] !== 6'd7 || emptyV[0] !== 1'b1) begin failures++; $display("FAIL byp_comb got=%0d/%b exp=7/1", dOutV[0], emptyV[0]); end
    checks++; if (dOutV[2] !== 6'd0) begin failures++; $display("FAIL nobyp_comb got=%0d exp=0", dOutV[2]); end
    step();
    wEn = 1'b0; rEn = 1'b0; #1;
    checks++; if (countV[0] !== 3'd0 || emptyV[0] !== 1'b1 || unfV[0] !== 1'b0) begin failures++; $display("FAIL byp_after got=%0d/%b/%b exp=0/1/0", countV[0], emptyV[0], unfV[0]); end
    checks++; if (unfV[2] !== 1'b1 || countV[2] !== 3'd1) begin failures++; $display("FAIL nobyp_after got=%b/%0d exp=1/1", unfV[2], countV[2]); end
    checks++; if (dOutV[2] !== 6'd7 || emptyV[2] !== 1'b0) begin failures++; $display("FAIL nobyp_dout got=%0d/%b exp=7/0", dOutV[2], emptyV[2]); end
    rEn = 1'b1;
    step();
    rEn = 1'b0; #1;
  endtask

  task automatic test_wrap();
    int nw = 0;
    int nr = 0;
    bit w, r;
    for (int cyc = 0; cyc < 400 && nr < 12; cyc++) begin
      w = (nw < 12) && ($urandom_range(0, 2) != 0) && (countV[1] < 3'd5);
      r = (countV[1] != 3'd0) && ($urandom_range(0, 2) != 0);
      wEn = w; rEn = r; dIn = 6'(nw); #1;
      if (r) begin
        checks++; if (dOutV[1] !== 6'(nr)) begin failures++; $display("FAIL wrap_order got=%0d exp=%0d", dOutV[1], nr); end
        nr++;
      end
      if (w) nw++;
      step();
      checks++; if (countV[1] > 3'd5) begin failures++; $display("FAIL wrap_count got=%0d exp<=5", countV[1]); end
    end
    wEn = 1'b0; rEn = 1'b0; #1;
    checks++; if (nr != 12) begin failures++; $display("FAIL wrap_timeout got=%0d exp=12 words", nr); end
    checks++; if (emptyV[1] !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", emptyV[1]); end
  endtask

  task automatic test_midreset();
    rst = 1'b0; step(); rst = 1'b1;
    for (int v = 5; v <= 7; v++) begin
      wEn = 1'b1; dIn = 6'(v);
      step();
    end
    wEn = 1'b0; #1;
    checks++; if (countV[0] !== 3'd3) begin failures++; $display("FAIL mid_pre got=%0d exp=3", countV[0]); end
    rst = 1'b0; wEn = 1'b1; rEn = 1'b1; dIn = 6'd1;
    step();
    wEn = 1'b0; rEn = 1'b0; #1;
    checks++; if (countV[0] !== 3'd0 || emptyV[0] !== 1'b1 || fullV[0] !== 1'b0) begin failures++; $display("FAIL mid_state got=%0d/%b/%b exp=0/1/0", countV[0], emptyV[0], fullV[0]); end
    checks++; if (afV[0] !== 1'b0 || aeV[0] !== 1'b1) begin failures++; $display("FAIL mid_flags got=%b/%b exp=0/1", afV[0], aeV[0]); end
    checks++; if (ovfV[0] !== 1'b0 || unfV[0] !== 1'b0 || dOutV[0] !== 6'd0) begin failures++; $display("FAIL mid_out got=%b/%b/%0d exp=0/0/0", ovfV[0], unfV[0], dOutV[0]); end
    rst = 1'b1; wEn = 1'b1; dIn = 6'd11;
    step();
    wEn = 1'b0; #1;
    checks++; if (countV[0] !== 3'd1 || dOutV[0] !== 6'd11) begin failures++; $display("FAIL mid_resume got=%0d/%0d exp=1/11", countV[0], dOutV[0]); end
  endtask

  task automatic test_random();
    rst = 1'b0; step(); rst = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int wBias;
      wBias = ((cyc / 40) % 2 == 0) ? 3 : 1;
      rst = ($urandom_range(0, 80) != 0);
      wEn = ($urandom_range(0, 3) < wBias);
      rEn = ($urandom_range(0, 3) >= wBias);
      if ($urandom_range(0, 5) == 0) rEn = wEn;
      dIn = 6'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++; if (countV[i] !== 3'(msz[i])) begin failures++; $display("FAIL rnd_count dut%0d cyc%0d got=%0d exp=%0d", i, cyc, countV[i], msz[i]); end
        checks++; if (fullV[i] !== (msz[i] == depthM[i]) || emptyV[i] !== (msz[i] == 0)) begin failures++; $display("FAIL rnd_fe dut%0d cyc%0d got=%b%b size=%0d", i, cyc, fullV[i], emptyV[i], msz[i]); end
        checks++; if (afV[i] !== (msz[i] >= afM[i]) || aeV[i] !== (msz[i] <= aeM[i])) begin failures++; $display("FAIL rnd_almost dut%0d cyc%0d got=%b%b size=%0d", i, cyc, afV[i], aeV[i], msz[i]); end
        checks++; if (ovfV[i] !== mOvf[i] || unfV[i] !== mUnf[i]) begin failures++; $display("FAIL rnd_err dut%0d cyc%0d got=%b%b exp=%b%b", i, cyc, ovfV[i], unfV[i], mOvf[i], mUnf[i]); end
        checks++; if (dOutV[i] !== expOut(i)) begin failures++; $display("FAIL rnd_dout dut%0d cyc%0d got=%0d exp=%0d", i, cyc, dOutV[i], expOut(i)); end
      end
      step();
    end
    rst = 1'b1; wEn = 1'b0; rEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_errors();
    test_bypass();
    test_wrap();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock show-ahead FIFO; next generation of the existing SyncFIFO. Generalises width and depth (non-power-of-two allowed), adds occupancy count, programmable almost-full/almost-empty flags, sticky-free overflow/underflow error pulses, and a selectable empty-bypass mode. Sits between any producer/consumer pair in the same clock domain. Drop-in for SyncFIFO when `BYPASS=1` and thresholds are unused.

## Interface
- `WIDTH`, default 6: data width in bits, ≥1.
- `DEPTH`, default 4: number of entries, ≥2, any integer.
- `AF_THRESH`, default DEPTH-1: `almostFull` asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, default 1: `almostEmpty` asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- `BYPASS`, default 1: 1 = empty-bypass enabled (simultaneous write+read on empty passes `dIn` through); 0 = disabled.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-low (rst=0 at a rising edge resets).
- `wEn` input 1: push request.
- `dIn` input WIDTH: push data.
- `rEn` input 1: pop request (head is always visible on `dOut`; rEn pops it).
- `dOut` output WIDTH: head entry (show-ahead).
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almostFull` output 1: count ≥ AF_THRESH.
- `almostEmpty` output 1: count ≤ AE_THRESH.
- `count` output $clog2(DEPTH+1): current occupancy.
- `overflow` output 1: one-cycle pulse, rejected write.
- `underflow` output 1: one-cycle pulse, rejected read.

## Operation
- Write accepted: `wEn && (!full || rEn)`. Read accepted: `rEn && (!empty || (BYPASS && wEn))`.
- Accepted write stores `dIn` at write pointer; accepted read advances read pointer. Pointers run 0..DEPTH-1 and wrap DEPTH-1 → 0 explicitly (no power-of-two masking).
- count: +1 on write-only, −1 on read-only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Full with wEn & rEn: pop head and push `dIn` same edge; count stays DEPTH; full stays 1.
- Empty with wEn & rEn & BYPASS=1: `dOut` = `dIn` combinationally that cycle; nothing stored; count stays 0; empty stays 1.
- Empty with wEn & rEn & BYPASS=0: write accepted, read rejected (underflow pulse); count → 1.
- Rejected write (wEn, full, !rEn): data dropped, state unchanged, `overflow`=1 next cycle.
- Rejected read (rEn, empty, not bypassed): state unchanged, `underflow`=1 next cycle.
- `dOut` when empty and not bypassing: all zeros.
- Reset: pointers 0, count 0, empty 1, full 0, almostEmpty 1, almostFull 0, overflow 0, underflow 0, dOut 0. Storage array not reset. Reset wins over concurrent wEn/rEn; mid-burst reset discards all contents.

## Timing
- Flags, count, error pulses are registered (or decoded purely from registered count); they reflect accepted operations one cycle after the edge.
- Write-to-read latency: word written at edge N visible on `dOut` after edge N (empty falls same edge).
- `dOut` combinational from read pointer and storage (plus `dIn`/`wEn`/`rEn` in bypass); settles within the cycle, stable before next edge.
- No combinational path from `rEn`/`wEn` to `full`/`empty`.

## Structure
- Shared header `fifo_defs`: count-width function ($clog2(DEPTH+1)) and pointer-increment-with-wrap function, reused by future async FIFO.
- One sub-module `fifo_mem`: WIDTH×DEPTH register array, synchronous write port, asynchronous read port; no reset.
- Top holds pointers, count, flag and error logic, bypass mux.

## Test plan
- WIDTH=6, DEPTH=4: reset, write 1,2,3,4 -> full=1 after 4th edge, count=4, almostFull=1 from count 3, dOut=1; pop four -> dOut 1,2,3,4, then empty=1, dOut=0.
- DEPTH=5: push/pop 12 words staggered so pointers wrap twice -> output sequence 0..11 in order, count never >5.
- Full + wEn + rEn with dIn=9 -> head popped, 9 stored at tail, count stays 4, no overflow.
- Empty + wEn + rEn, dIn=7: BYPASS=1 -> dOut=7 same cycle, empty stays 1, count 0; BYPASS=0 -> underflow=1 next cycle, count=1, dOut=7 after edge.
- wEn on full without rEn -> overflow pulse exactly one cycle, contents unchanged; rEn on empty without wEn -> underflow pulse one cycle.
- rst=0 asserted mid-burst with count=3 -> next edge count=0, empty=1, flags at reset values; writes resume correctly after rst=1.
